decode_issue: RTL and testbench

//  Operand-fetch/issue stage directly upstream of the ALU. Accepts 16-bit instruction

---
 rtl/decode_issue_if.sv | 34 +++
 rtl/decode_issue.sv | 142 ++++++++++++++
 tb/tb_decode_issue.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// Stream, ALU-operation and write-back signals of the decode/issue stage.
// The master side drives instruction words, consumer ready and write-back.
// The slave side is the stage itself.
interface decode_issue_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        OpcodeB;
  logic [1:0]        Mode;
  logic              useAU;
  logic [DATA_W-1:0] Immediate;
  logic [DATA_W-1:0] Rn_data;
  logic [DATA_W-1:0] Rm_data;
  logic [REG_AW-1:0] Rd_addr;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output flush, in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, OpcodeB, Mode, useAU, Immediate, Rn_data, Rm_data, Rd_addr
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, OpcodeB, Mode, useAU, Immediate, Rn_data, Rm_data, Rd_addr
  );
endinterface

// File: rtl/decode_issue.sv
// Operand-fetch/issue stage in front of the ALU. Decodes 16-bit instruction
// words (optionally followed by an immediate word), reads Rn/Rm from the
// internal register file with write-first bypass and presents one registered
// ALU operation per issue. Also owns the write-back port into the file.
module decode_issue #(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned NREGS  = 8,
  localparam int unsigned REG_AW = $clog2(NREGS)
) (
  input logic           clk,
  input logic           reset,
  decode_issue_if.slave bus
);

  typedef enum logic [1:0] {StFetch, StImm, StIssue} state_e;

  state_e            r_state;
  logic [15:0]       r_word0;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_out_valid;
  logic [3:0]        r_opcode;
  logic [1:0]        r_mode;
  logic              r_use_au;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_rn_data;
  logic [DATA_W-1:0] r_rm_data;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rn_addr;
  logic [REG_AW-1:0] r_rm_addr;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_drain;
  logic              w_load;
  logic              w_latch;
  logic [15:0]       w_dec_word;
  logic [REG_AW-1:0] w_rn_a;
  logic [REG_AW-1:0] w_rm_a;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rn_val;
  logic [DATA_W-1:0] w_rm_val;
  logic              w_wb_live;

  // Handshake: flush blocks acceptance; an issued op only frees the slot when drained.
  always_comb begin
    w_in_ready = 1'b0;
    if (!bus.flush) begin
      case (r_state)
        StFetch, StImm: w_in_ready = 1'b1;
        StIssue:        w_in_ready = bus.out_ready;
        default:        w_in_ready = 1'b0;
      endcase
    end
  end

  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_drain    = (r_state == StIssue) & bus.out_ready;
  // In IMM the accepted word is the immediate; the op fields come from the held word0.
  assign w_dec_word = (r_state == StImm) ? r_word0 : bus.in_instr;
  assign w_load     = w_accept & ((r_state == StImm) | (bus.in_instr[14:13] != 2'b11));
  assign w_latch    = w_accept & (r_state != StImm) & (bus.in_instr[14:13] == 2'b11);
  assign w_rn_a     = REG_AW'(w_dec_word[5:3]);
  assign w_rm_a     = REG_AW'(w_dec_word[2:0]);
  assign w_imm      = (r_state == StImm) ? DATA_W'(bus.in_instr)
                                         : {{(DATA_W-3){w_dec_word[2]}}, w_dec_word[2:0]};
  assign w_wb_live  = bus.wb_en & (bus.wb_addr != '0);

  // Operand read with write-first bypass; R0 is hard-wired to zero.
  always_comb begin
    w_rn_val = r_regs[w_rn_a];
    w_rm_val = r_regs[w_rm_a];
    if (w_wb_live && bus.wb_addr == w_rn_a) w_rn_val = bus.wb_data;
    if (w_wb_live && bus.wb_addr == w_rm_a) w_rm_val = bus.wb_data;
    if (w_rn_a == '0) w_rn_val = '0;
    if (w_rm_a == '0) w_rm_val = '0;
  end

  // Issue FSM with registered ALU-operation outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StFetch;
      r_word0     <= '0;
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_mode      <= '0;
      r_use_au    <= 1'b0;
      r_imm       <= '0;
      r_rn_data   <= '0;
      r_rm_data   <= '0;
      r_rd        <= '0;
      r_rn_addr   <= '0;
      r_rm_addr   <= '0;
    end else if (bus.flush) begin
      r_state     <= StFetch;
      r_word0     <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_state     <= StIssue;
      r_out_valid <= 1'b1;
      r_use_au    <= w_dec_word[15];
      r_mode      <= w_dec_word[14:13];
      r_opcode    <= w_dec_word[12:9];
      r_rd        <= REG_AW'(w_dec_word[8:6]);
      r_rn_addr   <= w_rn_a;
      r_rm_addr   <= w_rm_a;
      r_imm       <= w_imm;
      r_rn_data   <= w_rn_val;
      r_rm_data   <= w_rm_val;
    end else if (w_latch) begin
      r_state     <= StImm;
      r_word0     <= bus.in_instr;
      r_out_valid <= 1'b0;
    end else if (w_drain) begin
      r_state     <= StFetch;
      r_out_valid <= 1'b0;
    end else if (r_state == StIssue && w_wb_live) begin
      // Held op snoops write-back so it never issues a stale operand.
      if (bus.wb_addr == r_rn_addr) r_rn_data <= bus.wb_data;
      if (bus.wb_addr == r_rm_addr) r_rm_data <= bus.wb_data;
    end
  end

  // Register file write port, independent of issue state and flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb_live) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.OpcodeB   = r_opcode;
  assign bus.Mode      = r_mode;
  assign bus.useAU     = r_use_au;
  assign bus.Immediate = r_imm;
  assign bus.Rn_data   = r_rn_data;
  assign bus.Rm_data   = r_rm_data;
  assign bus.Rd_addr   = r_rd;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios followed by random traffic, all
// checked against a transaction-level model (pending-op slot plus register array).
module tb_decode_issue;

  logic clk;
  logic reset;

  decode_issue_if #(.DATA_W(16), .REG_AW(3)) bus ();

  decode_issue #(.DATA_W(16), .NREGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  opc;
    logic [1:0]  mode;
    logic        au;
    logic [15:0] imm;
    logic [15:0] rn_d;
    logic [15:0] rm_d;
    logic [2:0]  rd;
    logic [2:0]  rn_a;
    logic [2:0]  rm_a;
  } op_t;

  int          n_tests;
  int          n_fail;
  logic [15:0] m_regs [8];
  logic        m_pend;
  op_t         m_op;
  logic        m_w0v;
  logic [15:0] m_w0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic fl, input logic iv, input logic [15:0] ins, input logic ordy,
                     input logic we, input logic [2:0] wa, input logic [15:0] wd);
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.wb_en     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
  endtask

  task automatic model_reset();
    m_pend = 1'b0;
    m_w0v  = 1'b0;
    m_w0   = '0;
    m_op   = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
  endtask

  // Register value seen by an operand read this cycle (write-first, R0 = 0).
  function automatic logic [15:0] rd_reg(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  function automatic op_t mk_op(input logic [15:0] w0, input logic [15:0] imm);
    op_t o;
    o.au   = w0[15];
    o.mode = w0[14:13];
    o.opc  = w0[12:9];
    o.rd   = w0[8:6];
    o.rn_a = w0[5:3];
    o.rm_a = w0[2:0];
    o.imm  = imm;
    o.rn_d = rd_reg(w0[5:3]);
    o.rm_d = rd_reg(w0[2:0]);
    return o;
  endfunction

  function automatic logic [63:0] dut_op();
    return {6'd0, bus.OpcodeB, bus.Mode, bus.useAU, bus.Immediate, bus.Rn_data, bus.Rm_data,
            bus.Rd_addr};
  endfunction

  function automatic logic [63:0] mdl_op();
    return {6'd0, m_op.opc, m_op.mode, m_op.au, m_op.imm, m_op.rn_d, m_op.rm_d, m_op.rd};
  endfunction

  // One clock: check against the model, advance the model, cross the edge.
  task automatic cyc();
    logic exp_rdy;
    logic acc;
    #1;
    exp_rdy = !bus.flush && (!m_pend || bus.out_ready);
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_pend});
    if (m_pend) chk("op", dut_op(), mdl_op());
    acc = bus.in_valid && exp_rdy;
    if (bus.flush) begin
      m_pend = 1'b0;
      m_w0v  = 1'b0;
    end else begin
      if (m_pend && !bus.out_ready && bus.wb_en && bus.wb_addr != 3'd0) begin
        if (bus.wb_addr == m_op.rn_a) m_op.rn_d = bus.wb_data;
        if (bus.wb_addr == m_op.rm_a) m_op.rm_d = bus.wb_data;
      end
      if (m_pend && bus.out_ready) m_pend = 1'b0;
      if (acc) begin
        if (m_w0v) begin
          m_op   = mk_op(m_w0, bus.in_instr);
          m_pend = 1'b1;
          m_w0v  = 1'b0;
        end else if (bus.in_instr[14:13] == 2'b11) begin
          m_w0  = bus.in_instr;
          m_w0v = 1'b1;
        end else begin
          m_op   = mk_op(bus.in_instr, {{13{bus.in_instr[2]}}, bus.in_instr[2:0]});
          m_pend = 1'b1;
        end
      end
    end
    if (bus.wb_en && bus.wb_addr != 3'd0) m_regs[bus.wb_addr] = bus.wb_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] w;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drv(0, 0, 16'h0, 0, 0, 3'd0, 16'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // Reset state: FETCH (ready), no op, all op fields zero.
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_op", dut_op(), 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    reset = 1'b0;

    // T1: single-word op, Immediate = sext(word0[2:0]) = 0x0002.
    drv(0, 0, 16'h0, 1, 1, 3'd1, 16'h0005); cyc();
    drv(0, 0, 16'h0, 1, 1, 3'd2, 16'h0003); cyc();
    drv(0, 1, 16'h8A0A, 1, 0, 3'd0, 16'h0); cyc();
    chk("t1_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("t1_fields", {bus.useAU, bus.Mode, bus.OpcodeB, bus.Rn_data, bus.Rm_data, bus.Immediate},
        {1'b1, 2'd0, 4'd5, 16'h0005, 16'h0003, 16'h0002});
    drv(0, 0, 16'h0, 1, 0, 3'd0, 16'h0); cyc();
    chk("t1_drop", {63'd0, bus.out_valid}, 64'd0);

    // T2: two-word op; nothing issues until the immediate word.
    drv(0, 1, 16'hE051, 1, 0, 3'd0, 16'h0); cyc();
    chk("t2_wait", {63'd0, bus.out_valid}, 64'd0);
    drv(0, 1, 16'h1234, 1, 0, 3'd0, 16'h0);
    #1 chk("t2_imm_ready", {63'd0, bus.in_ready}, 64'd1);
    cyc();
    chk("t2_fields", {bus.out_valid, bus.Mode, bus.Immediate, bus.Rn_data, bus.Rm_data},
        {1'b1, 2'd3, 16'h1234, 16'h0003, 16'h0005});
    drv(0, 0, 16'h0, 1, 0, 3'd0, 16'h0); cyc();

    // T3: hold for 3 cycles, write-back into held Rn during the hold.
    drv(0, 1, 16'h8A0A, 0, 0, 3'd0, 16'h0); cyc();
    drv(0, 1, 16'h0249, 0, 1, 3'd1, 16'h00FF); cyc();
    drv(0, 1, 16'h0249, 0, 0, 3'd0, 16'h0); cyc();
    drv(0, 1, 16'h0249, 0, 0, 3'd0, 16'h0); cyc();
    chk("t3_held_rn", {48'd0, bus.Rn_data}, {48'd0, 16'h00FF});
    drv(0, 0, 16'h0, 1, 0, 3'd0, 16'h0); cyc();
    drv(0, 0, 16'h0, 1, 0, 3'd0, 16'h0); cyc();
    chk("t3_consumed", {63'd0, bus.out_valid}, 64'd0);

    // T4: same-edge bypass into Rn=3, then a write to R0 must not leak.
    drv(0, 1, 16'h0318, 1, 1, 3'd3, 16'hBEEF); cyc();
    chk("t4_bypass", {48'd0, bus.Rn_data}, {48'd0, 16'hBEEF});
    drv(0, 1, 16'h0300, 1, 1, 3'd0, 16'h1234); cyc();
    chk("t4_r0", {48'd0, bus.Rn_data}, 64'd0);
    drv(0, 0, 16'h0, 1, 0, 3'd0, 16'h0); cyc();

    // T5: four back-to-back single-word ops issue on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      w = {1'b0, 2'b01, 4'(i + 1), 3'(i), 3'd1, 3'd2};
      drv(0, 1, w, 1, 0, 3'd0, 16'h0); cyc();
      chk("t5_seq", {59'd0, bus.out_valid, bus.OpcodeB}, {59'd0, 1'b1, 4'(i + 1)});
    end
    drv(0, 0, 16'h0, 1, 0, 3'd0, 16'h0); cyc();

    // T6: flush in IMM, next word is word0; then async reset while issuing.
    drv(0, 1, 16'hE051, 1, 0, 3'd0, 16'h0); cyc();
    drv(1, 1, 16'h1234, 1, 0, 3'd0, 16'h0); cyc();
    drv(0, 1, 16'h8A0A, 1, 0, 3'd0, 16'h0); cyc();
    chk("t6_word0", {58'd0, bus.out_valid, bus.Mode, bus.OpcodeB}, {58'd0, 1'b1, 2'd0, 4'd5});
    drv(0, 0, 16'h0, 0, 0, 3'd0, 16'h0);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("t6_async_op", dut_op(), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drv(0, 1, 16'h8A0A, 1, 0, 3'd0, 16'h0); cyc();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[14:13] = 2'b11;
      drv(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7), w,
          ($urandom_range(0, 9) < 7), 1'($urandom), 3'($urandom), 16'($urandom));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
